// File: rtl/a_pkg.sv
// Shared definitions for the a_* asynchronous channel blocks and their clocked bridges.
package a_pkg;

  // Smallest legal synchroniser depth and FIFO depth.
  localparam int unsigned A_SYNC_MIN = 2;

  // Pointer width for a power-of-two FIFO: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/a_sync_ff.sv
// Multi-stage flop chain for bringing a single asynchronous level into the clk domain.
(* keep_hierarchy = "yes" *)
module a_sync_ff #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {Stages{RstVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/a_sync_sink.sv
// Clocked sink for a two-phase bundled-data channel, buffering tokens into a valid/ready FIFO.
// Define A_SYNC_SINK_LEVEL_EN to expose the registered FIFO occupancy on level_o.
module a_sync_sink
  import a_pkg::*;
#(
  parameter int unsigned N           = 1,
  parameter logic        Rpol        = 1'b0,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          r_i,
  output logic                          a_i,
  input  logic [N-1:0]                  d_i,
  output logic                          valid_o,
  input  logic                          ready_i,
`ifdef A_SYNC_SINK_LEVEL_EN
  output logic [ptr_width(DEPTH)-1:0]   level_o,
`endif
  output logic [N-1:0]                  data_o
);

  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic         req_s;
  logic         a_q;
  ptr_t         wr_ptr_q, rd_ptr_q;
  logic [N-1:0] mem_q [DEPTH];
  logic         pending, full, empty, push, pop;

  a_sync_ff #(
    .Stages (SYNC_STAGES),
    .RstVal (Rpol)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (r_i),
    .q_o (req_s)
  );

  // A token is outstanding whenever the synchronised request differs from our ack.
  assign pending = (req_s != a_q);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign push    = pending && !full;
  assign pop     = !empty && ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= Rpol;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        a_q      <= ~a_q;
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
    end
  end

  // Storage is cleared so data_o reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= d_i;
    end
  end

`ifdef A_SYNC_SINK_LEVEL_EN
  ptr_t level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_q <= level_q + ptr_t'(1);
        2'b01:   level_q <= level_q - ptr_t'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign level_o = level_q;
`endif

  assign a_i     = a_q;
  assign valid_o = !empty;
  assign data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: tb/tb_a_sync_sink.sv
// Directed bench for a_sync_sink: one Rpol=0 instance and one Rpol=1 instance on a shared reset.
module tb_a_sync_sink;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0, a0, valid0, ready0;
  logic [W-1:0] d0, data0;
  logic         r1, a1, valid1, ready1;
  logic [W-1:0] d1, data1;
`ifdef A_SYNC_SINK_LEVEL_EN
  logic [2:0]   level0, level1;
`endif

  int   compared   = 0;
  int   mismatched = 0;
  logic a0_exp;

  always #5 clk = ~clk;

  a_sync_sink #(
    .N           (W),
    .Rpol        (1'b0),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut0 (
    .clk     (clk),
    .rst     (rst),
    .r_i     (r0),
    .a_i     (a0),
    .d_i     (d0),
    .valid_o (valid0),
    .ready_i (ready0),
`ifdef A_SYNC_SINK_LEVEL_EN
    .level_o (level0),
`endif
    .data_o  (data0)
  );

  a_sync_sink #(
    .N           (W),
    .Rpol        (1'b1),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut1 (
    .clk     (clk),
    .rst     (rst),
    .r_i     (r1),
    .a_i     (a1),
    .d_i     (d1),
    .valid_o (valid1),
    .ready_i (ready1),
`ifdef A_SYNC_SINK_LEVEL_EN
    .level_o (level1),
`endif
    .data_o  (data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send0(input logic [W-1:0] v);
    @(negedge clk);
    d0 = v;
    r0 = ~r0;
  endtask

  // Returns the number of edges until a0 toggles, or 0 if it never does within the bound.
  task automatic wait_ack0(output int edges);
    edges = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (a0 !== a0_exp) begin
        edges = i;
        break;
      end
    end
    if (edges != 0) a0_exp = ~a0_exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int sent, got, acks;
    logic a_prev;

    rst = 1'b1;
    r0 = 1'b0; d0 = '0; ready0 = 1'b0;
    r1 = 1'b1; d1 = '0; ready1 = 1'b0;
    a0_exp = 1'b0;

    // Reset state of both instances.
    #12;
    check("rst_a0", a0, 0);
    check("rst_valid0", valid0, 0);
    check("rst_data0", data0, 0);
    check("rst_a1", a1, 1);
    check("rst_valid1", valid1, 0);
`ifdef A_SYNC_SINK_LEVEL_EN
    check("rst_level0", level0, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single token: ack three edges after the request, head visible with it.
    send0(8'h01);
    wait_ack0(e);
    check("t1_latency", e, 3);
    check("t1_valid", valid0, 1);
    check("t1_data", data0, 8'h01);
    @(negedge clk);
    ready0 = 1'b1;
    @(posedge clk);
    #1;
    check("t1_pop_valid", valid0, 0);
    ready0 = 1'b0;

    // Backpressure: four tokens fill the FIFO, the fifth is held on the channel.
    for (int k = 1; k <= 4; k++) begin
      send0(W'(k));
      wait_ack0(e);
      check("t2_ack_latency", e, 3);
    end
`ifdef A_SYNC_SINK_LEVEL_EN
    check("t2_level_full", level0, 4);
`endif
    check("t2_head", data0, 8'h01);
    send0(8'h05);
    wait_ack0(e);
    check("t2_fifth_held", e, 0);
    check("t2_a_unchanged", a0, a0_exp);
    @(negedge clk);
    ready0 = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      check("t2_drain_valid", valid0, 1);
      check("t2_drain_data", data0, j);
      @(negedge clk);
    end
    check("t2_empty", valid0, 0);
    a0_exp = ~a0_exp;
    check("t2_fifth_acked", a0, a0_exp);
    ready0 = 1'b0;

    // Push and pop on the same edge with three entries queued.
    send0(8'h0A); wait_ack0(e);
    send0(8'h0B); wait_ack0(e);
    send0(8'h0C); wait_ack0(e);
    send0(8'h0D);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ready0 = 1'b1;
    @(negedge clk);
    ready0 = 1'b0;
    a0_exp = ~a0_exp;
    check("t3_ack", a0, a0_exp);
    check("t3_valid", valid0, 1);
    check("t3_head", data0, 8'h0B);
`ifdef A_SYNC_SINK_LEVEL_EN
    check("t3_level", level0, 3);
`endif
    ready0 = 1'b1;
    check("t3_order_b", data0, 8'h0B);
    @(negedge clk);
    check("t3_order_c", data0, 8'h0C);
    @(negedge clk);
    check("t3_order_d", data0, 8'h0D);
    @(negedge clk);
    check("t3_empty", valid0, 0);
    ready0 = 1'b0;

    // Wrap-around: 20 tokens with random downstream stalls.
    sent = 0; got = 0; acks = 0;
    a_prev = a0;
    for (int cyc = 0; cyc < 3000 && got < 20; cyc++) begin
      @(negedge clk);
      if (a0 !== a_prev) begin
        acks++;
        a_prev = a0;
      end
      if (sent < 20 && acks == sent) begin
        d0 = W'(8'h20 + sent);
        r0 = ~r0;
        sent++;
      end
      ready0 = ($urandom_range(0, 2) != 0);
      if (valid0 && ready0) begin
        check("t4_data", 32'(data0), 32'(8'h20 + got));
        got++;
      end
    end
    @(negedge clk);
    ready0 = 1'b0;
    check("t4_received", got, 20);
    check("t4_acks", acks, 20);
    check("t4_a_level", a0, a0_exp);
    check("t4_empty", valid0, 0);

    // Asynchronous reset with two entries queued and a third token pending.
    send0(8'h31); wait_ack0(e);
    send0(8'h32); wait_ack0(e);
    send0(8'h33);
    @(posedge clk);
    #2;
    rst = 1'b1;
    r0 = 1'b0;
    #1;
    a0_exp = 1'b0;
    check("t5_valid_now", valid0, 0);
    check("t5_a_now", a0, 0);
    check("t5_data_now", data0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_token_valid", valid0, 0);
    check("t5_no_token_a", a0, 0);

    // Rpol=1 instance: idle high, accepts a 1->0 request.
    check("t6_idle_a", a1, 1);
    check("t6_idle_valid", valid1, 0);
    @(negedge clk);
    d1 = 8'h5A;
    r1 = 1'b0;
    e = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (a1 !== 1'b1) begin
        e = i;
        break;
      end
    end
    check("t6_latency", e, 3);
    check("t6_a", a1, 0);
    check("t6_valid", valid1, 1);
    check("t6_data", data1, 8'h5A);
    @(negedge clk);
    ready1 = 1'b1;
    @(posedge clk);
    #1;
    check("t6_pop", valid1, 0);
    ready1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
